// File: rtl/alu_issue_wb_pkg.sv
// Shared definitions for the ALU issue/write-back slice: widths, ALU function
// codes and Status bit positions.
package alu_issue_wb_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 3;
  localparam int STATUS_W = 5;

  localparam int ST_Z = 0;
  localparam int ST_C = 1;
  localparam int ST_V = 2;
  localparam int ST_N = 3;
  localparam int ST_D = 4;

  typedef enum logic [3:0] {
    FS_PASSA = 4'h0,
    FS_ADD   = 4'h1,
    FS_SUB   = 4'h2,
    FS_AND   = 4'h3,
    FS_OR    = 4'h4,
    FS_XOR   = 4'h5,
    FS_NOT   = 4'h6,
    FS_SHL   = 4'h7,
    FS_SHR   = 4'h8,
    FS_EQ    = 4'h9
  } fs_e;

endpackage

// File: rtl/alu_issue_wb_if.sv
// Bundle of decoder, ALU and write-back signals around alu_issue_wb.
// master = decoder/ALU side, slave = the issue/write-back block.
interface alu_issue_wb_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] imm;
  logic          b_imm_sel;
  logic [3:0]    fs_in;
  logic [2:0]    sh_in;
  logic          wb_en;
  logic          flag_we;

  logic [DW-1:0] OprdA;
  logic [DW-1:0] OprdB;
  logic [3:0]    FS;
  logic [2:0]    SH;
  logic [DW-1:0] FOut;
  logic          Z, C, V, N, D;

  logic [4:0]    Status;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  modport master (
    output instr_valid, ra_addr, rb_addr, rd_addr, imm, b_imm_sel,
           fs_in, sh_in, wb_en, flag_we, FOut, Z, C, V, N, D,
    input  instr_ready, OprdA, OprdB, FS, SH, Status, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, ra_addr, rb_addr, rd_addr, imm, b_imm_sel,
           fs_in, sh_in, wb_en, flag_we, FOut, Z, C, V, N, D,
    output instr_ready, OprdA, OprdB, FS, SH, Status, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_issue_wb_regfile.sv
// General register file: 2**AW entries of DW bits, two asynchronous read
// ports, one synchronous write port, synchronous active-low clear.
module alu_regfile #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_raAddr,
  input  logic [AW-1:0] i_rbAddr,
  output logic [DW-1:0] o_raData,
  output logic [DW-1:0] o_rbData,
  input  logic          i_we,
  input  logic [AW-1:0] i_wAddr,
  input  logic [DW-1:0] i_wData
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  assign o_raData = r_mem[i_raAddr];
  assign o_rbData = r_mem[i_rbAddr];

endmodule

// File: rtl/alu_issue_wb.sv
// Two-stage operand issue / write-back wrapper around an external combinational ALU.
// Define ALU_BYPASS_EN to forward FOut on RAW hazards instead of stalling one cycle.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  alu_issue_wb_if.slave bus
);

  logic                r_exValid;
  logic                r_exWb;
  logic                r_exFlagWe;
  logic [AW-1:0]       r_exRd;
  logic [DW-1:0]       r_oprdA;
  logic [DW-1:0]       r_oprdB;
  logic [3:0]          r_fs;
  logic [2:0]          r_sh;
  logic [STATUS_W-1:0] r_status;
  logic                r_wbValid;
  logic [AW-1:0]       r_wbAddr;
  logic [DW-1:0]       r_wbData;

  logic [DW-1:0] w_raData;
  logic [DW-1:0] w_rbData;
  logic [DW-1:0] w_srcA;
  logic [DW-1:0] w_srcB;
  logic          w_wbWe;
  logic          w_hitA;
  logic          w_hitB;
  logic          w_transfer;

  alu_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raAddr (bus.ra_addr),
    .i_rbAddr (bus.rb_addr),
    .o_raData (w_raData),
    .o_rbData (w_rbData),
    .i_we     (w_wbWe),
    .i_wAddr  (r_exRd),
    .i_wData  (bus.FOut)
  );

  // A source hits when the instruction in execute is about to write it back.
  assign w_wbWe = r_exValid & r_exWb;
  assign w_hitA = w_wbWe & (bus.ra_addr == r_exRd);
  assign w_hitB = w_wbWe & !bus.b_imm_sel & (bus.rb_addr == r_exRd);

`ifdef ALU_BYPASS_EN
  assign bus.instr_ready = 1'b1;
  assign w_srcA = w_hitA ? bus.FOut : w_raData;
  assign w_srcB = bus.b_imm_sel ? bus.imm : (w_hitB ? bus.FOut : w_rbData);
`else
  logic w_hazard;
  assign w_hazard        = w_hitA | w_hitB;
  assign bus.instr_ready = !w_hazard;
  assign w_srcA = w_raData;
  assign w_srcB = bus.b_imm_sel ? bus.imm : w_rbData;
`endif

  assign w_transfer = bus.instr_valid & bus.instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exValid  <= 1'b0;
      r_exWb     <= 1'b0;
      r_exFlagWe <= 1'b0;
      r_exRd     <= '0;
      r_oprdA    <= '0;
      r_oprdB    <= '0;
      r_fs       <= '0;
      r_sh       <= '0;
      r_status   <= '0;
      r_wbValid  <= 1'b0;
      r_wbAddr   <= '0;
      r_wbData   <= '0;
    end else begin
      r_exValid <= w_transfer;
      if (w_transfer) begin
        r_oprdA    <= w_srcA;
        r_oprdB    <= w_srcB;
        r_fs       <= bus.fs_in;
        r_sh       <= bus.sh_in;
        r_exRd     <= bus.rd_addr;
        r_exWb     <= bus.wb_en;
        r_exFlagWe <= bus.flag_we;
      end

      r_wbValid <= w_wbWe;
      if (w_wbWe) begin
        r_wbAddr <= r_exRd;
        r_wbData <= bus.FOut;
      end

      if (r_exValid & r_exFlagWe) begin
        r_status[ST_Z] <= bus.Z;
        r_status[ST_C] <= bus.C;
        r_status[ST_V] <= bus.V;
        r_status[ST_N] <= bus.N;
        r_status[ST_D] <= bus.D;
      end
    end
  end

  assign bus.OprdA    = r_oprdA;
  assign bus.OprdB    = r_oprdB;
  assign bus.FS       = r_fs;
  assign bus.SH       = r_sh;
  assign bus.Status   = r_status;
  assign bus.wb_valid = r_wbValid;
  assign bus.wb_addr  = r_wbAddr;
  assign bus.wb_data  = r_wbData;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a behavioural ALU on the feedback path.
// Stall expectations follow ALU_BYPASS_EN.
module tb_alu_issue_wb;
  import alu_issue_wb_pkg::*;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wbExp_t;

  logic   clk;
  logic   rst_n;
  int     total;
  int     bad;
  int     stalls;
  wbExp_t expQ[$];

  logic [8:0] aluSum;
  logic [4:0] aluHalf;
  logic [7:0] aluF;
  logic       aluC, aluV, aluD;

  alu_issue_wb_if #(.DW(8), .AW(3)) bus ();

  alu_issue_wb #(.DW(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; D is the nibble carry of add/subtract.
  always_comb begin
    aluSum  = '0;
    aluHalf = '0;
    aluF    = bus.OprdA;
    aluC    = 1'b0;
    aluV    = 1'b0;
    aluD    = 1'b0;
    case (bus.FS)
      FS_ADD: begin
        aluSum  = {1'b0, bus.OprdA} + {1'b0, bus.OprdB};
        aluHalf = {1'b0, bus.OprdA[3:0]} + {1'b0, bus.OprdB[3:0]};
        aluF    = aluSum[7:0];
        aluC    = aluSum[8];
        aluD    = aluHalf[4];
        aluV    = (bus.OprdA[7] == bus.OprdB[7]) && (aluSum[7] != bus.OprdA[7]);
      end
      FS_SUB: begin
        aluSum  = {1'b0, bus.OprdA} + {1'b0, ~bus.OprdB} + 9'd1;
        aluHalf = {1'b0, bus.OprdA[3:0]} + {1'b0, ~bus.OprdB[3:0]} + 5'd1;
        aluF    = aluSum[7:0];
        aluC    = aluSum[8];
        aluD    = aluHalf[4];
        aluV    = (bus.OprdA[7] != bus.OprdB[7]) && (aluSum[7] != bus.OprdA[7]);
      end
      FS_OR:   aluF = bus.OprdA | bus.OprdB;
      FS_SHL:  aluF = bus.OprdA << bus.SH;
      FS_EQ:   aluF = bus.OprdA ^ bus.OprdB;
      default: aluF = bus.OprdA;
    endcase
  end

  assign bus.FOut = aluF;
  assign bus.Z    = (aluF == 8'h00);
  assign bus.C    = aluC;
  assign bus.V    = aluV;
  assign bus.N    = aluF[7];
  assign bus.D    = aluD;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one instruction, waits out any stall, queues the expected write-back.
  task automatic applyStimulus(input logic [3:0] fs, input logic [2:0] rd,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic [7:0] immV, input logic bsel,
                               input logic wb, input logic fl, input logic [2:0] sh,
                               input logic [7:0] expData, input logic pushExp,
                               output int nStall);
    nStall          = 0;
    bus.instr_valid = 1'b1;
    bus.fs_in       = fs;
    bus.rd_addr     = rd;
    bus.ra_addr     = ra;
    bus.rb_addr     = rb;
    bus.imm         = immV;
    bus.b_imm_sel   = bsel;
    bus.wb_en       = wb;
    bus.flag_we     = fl;
    bus.sh_in       = sh;
    #1;
    while (!bus.instr_ready && nStall < 8) begin
      @(posedge clk);
      #1;
      nStall++;
    end
    if (!bus.instr_ready) begin
      checkOutput("readyTimeout", 32'(bus.instr_ready), 32'd1);
      bus.instr_valid = 1'b0;
    end else begin
      if (wb && pushExp) expQ.push_back('{addr: rd, data: expData});
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
    end
  endtask

  // Monitor: every write-back pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.wb_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWb", {29'd0, bus.wb_addr}, 32'hFFFF_FFFF);
        end else begin
          wbExp_t e;
          e = expQ.pop_front();
          checkOutput("wbAddr", 32'(bus.wb_addr), 32'(e.addr));
          checkOutput("wbData", 32'(bus.wb_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expStall;
    total = 0;
    bad   = 0;
`ifdef ALU_BYPASS_EN
    expStall = 0;
`else
    expStall = 1;
`endif
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.ra_addr     = '0;
    bus.rb_addr     = '0;
    bus.rd_addr     = '0;
    bus.imm         = '0;
    bus.b_imm_sel   = 1'b0;
    bus.fs_in       = '0;
    bus.sh_in       = '0;
    bus.wb_en       = 1'b0;
    bus.flag_we     = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(1);

    checkOutput("rstStatus", 32'(bus.Status), 32'd0);
    checkOutput("rstOprdA", 32'(bus.OprdA), 32'd0);
    checkOutput("rstOprdB", 32'(bus.OprdB), 32'd0);
    checkOutput("rstFS", 32'(bus.FS), 32'd0);
    checkOutput("rstSH", 32'(bus.SH), 32'd0);
    checkOutput("rstWbValid", 32'(bus.wb_valid), 32'd0);
    checkOutput("rstWbAddr", 32'(bus.wb_addr), 32'd0);
    checkOutput("rstWbData", 32'(bus.wb_data), 32'd0);
    checkOutput("rstReady", 32'(bus.instr_ready), 32'd1);

    // Reset lands while ADD R1=R0+5 sits in execute: it must never write back.
    applyStimulus(FS_ADD, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b1, 1'b1, 3'd0, 8'h05, 1'b0, stalls);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("midRstWbValid", 32'(bus.wb_valid), 32'd0);
    waitCycles(2);
    checkOutput("midRstStatus", 32'(bus.Status), 32'd0);
    applyStimulus(FS_ADD, 3'd1, 3'd1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, stalls);
    waitCycles(3);

    // Immediate loads then register add.
    applyStimulus(FS_ADD, 3'd1, 3'd0, 3'd0, 8'h12, 1'b1, 1'b1, 1'b0, 3'd0, 8'h12, 1'b1, stalls);
    applyStimulus(FS_ADD, 3'd2, 3'd0, 3'd0, 8'h34, 1'b1, 1'b1, 1'b0, 3'd0, 8'h34, 1'b1, stalls);
    applyStimulus(FS_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h46, 1'b1, stalls);
    waitCycles(2);
    checkOutput("addStatus", 32'(bus.Status), 32'h00);

    // Back-to-back RAW on R1: 7F + 1 -> 80 with N, V and nibble carry.
    applyStimulus(FS_ADD, 3'd1, 3'd0, 3'd0, 8'h7F, 1'b1, 1'b1, 1'b0, 3'd0, 8'h7F, 1'b1, stalls);
    applyStimulus(FS_ADD, 3'd2, 3'd1, 3'd0, 8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 8'h80, 1'b1, stalls);
    checkOutput("rawStalls", 32'(stalls), 32'(expStall));
    waitCycles(2);
    checkOutput("rawStatus", 32'(bus.Status), 32'b11100);

    // SUB R4 = R3 - R3: zero with carry (no borrow) and nibble carry.
    applyStimulus(FS_SUB, 3'd4, 3'd3, 3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, stalls);
    waitCycles(2);
    checkOutput("subStatus", 32'(bus.Status), 32'b10011);

    // OR and shift without flag update leave Status alone.
    applyStimulus(FS_OR, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'hFF, 1'b1, stalls);
    applyStimulus(FS_SHL, 3'd6, 3'd5, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'hF8, 1'b1, stalls);
    waitCycles(2);
    checkOutput("orKeepStatus", 32'(bus.Status), 32'b10011);

    // Compare R1 with itself: flags only, no write-back.
    applyStimulus(FS_EQ, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, stalls);
    waitCycles(2);
    checkOutput("eqStatus", 32'(bus.Status), 32'b00001);

    // Read back registers by adding zero and writing to themselves.
    applyStimulus(FS_ADD, 3'd1, 3'd1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h7F, 1'b1, stalls);
    applyStimulus(FS_ADD, 3'd4, 3'd4, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, stalls);
    applyStimulus(FS_ADD, 3'd3, 3'd3, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h46, 1'b1, stalls);
    waitCycles(4);
    checkOutput("eqKeepStatus", 32'(bus.Status), 32'b00001);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
